// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch unit: datapath widths and fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int OPC_W  = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter with its next-value mux: jump load (direct or via accumulator) beats increment.
module pc_reg
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              CLB,
    input  logic              IncPC,
    input  logic              LoadPC,
    input  logic              SelPC,
    input  logic [DATA_W-1:0] Acc_in,
    input  logic [OPC_W-1:0]  ir_low,
    output logic [DATA_W-1:0] pc
);

    logic [DATA_W-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (LoadPC)
            pc_next = SelPC ? Acc_in : {{(DATA_W-OPC_W){1'b0}}, ir_low};
        else if (IncPC)
            pc_next = pc + 1'b1;
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB)
            pc <= '0;
        else
            pc <= pc_next;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, with ack timeout and sticky error.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic              clk,
    input  logic              CLB,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              LoadPC,
    input  logic              SelPC,
    input  logic [DATA_W-1:0] Acc_in,
    output logic [DATA_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic [OPC_W-1:0]  Opcode,
    output logic [OPC_W-1:0]  Operand,
    output logic [DATA_W-1:0] PC,
    output logic              IR_valid,
    output logic              fetch_busy,
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    fetch_state_t      state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] fetch_addr;
    logic [CNT_W-1:0]  cnt;

    pc_reg u_pc_reg (
        .clk    (clk),
        .CLB    (CLB),
        .IncPC  (IncPC),
        .LoadPC (LoadPC),
        .SelPC  (SelPC),
        .Acc_in (Acc_in),
        .ir_low (ir[OPC_W-1:0]),
        .pc     (PC)
    );

    // The address is captured at request time so PC jumps never disturb an in-flight read.
    assign imem_addr = fetch_addr;
    assign Opcode    = ir[DATA_W-1:OPC_W];
    assign Operand   = ir[OPC_W-1:0];

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state      <= IDLE;
            ir         <= '0;
            fetch_addr <= '0;
            cnt        <= '0;
            imem_req   <= 1'b0;
            IR_valid   <= 1'b0;
            fetch_busy <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LoadIR) begin
                        state      <= REQ;
                        fetch_addr <= PC;
                        IR_valid   <= 1'b0;
                        cnt        <= '0;
                        imem_req   <= 1'b1;
                        fetch_busy <= 1'b1;
                    end
                end
                REQ: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (imem_ack) begin
                        state      <= IDLE;
                        ir         <= imem_data;
                        IR_valid   <= 1'b1;
                        imem_req   <= 1'b0;
                        fetch_busy <= 1'b0;
                    end else if (cnt == LAST_WAIT) begin
                        state      <= ERR;
                        cnt        <= cnt + 1'b1;
                        imem_req   <= 1'b0;
                        fetch_busy <= 1'b0;
                        fetch_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a cycle-level behavioural reference.
module tb_instr_fetch;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       CLB;
    logic       LoadIR, IncPC, LoadPC, SelPC, imem_ack;
    logic [7:0] Acc_in;
    logic [7:0] imem_addr, imem_data, PC;
    logic       imem_req, IR_valid, fetch_busy, fetch_err;
    logic [3:0] Opcode, Operand;

    logic [7:0] mem [256];
    assign imem_data = mem[imem_addr];

    instr_fetch #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .CLB        (CLB),
        .LoadIR     (LoadIR),
        .IncPC      (IncPC),
        .LoadPC     (LoadPC),
        .SelPC      (SelPC),
        .Acc_in     (Acc_in),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .Opcode     (Opcode),
        .Operand    (Operand),
        .PC         (PC),
        .IR_valid   (IR_valid),
        .fetch_busy (fetch_busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: mode 0 = waiting for a request, 1 = read outstanding, 2 = stuck in error.
    int         m_mode  = 0;
    int         m_wait  = 0;
    logic [7:0] m_pc    = 8'h00;
    logic [7:0] m_ir    = 8'h00;
    logic [7:0] m_addr  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    logic [7:0] pc_n;

    always @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            m_mode = 0; m_wait = 0; m_pc = 8'h00; m_ir = 8'h00;
            m_addr = 8'h00; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            if (LoadPC)      pc_n = SelPC ? Acc_in : {4'h0, m_ir[3:0]};
            else if (IncPC)  pc_n = (m_pc + 8'd1) % 256;
            else             pc_n = m_pc;
            if (m_mode == 0) begin
                if (LoadIR) begin
                    m_mode = 1; m_addr = m_pc; m_valid = 1'b0; m_wait = 0;
                end
            end else if (m_mode == 1) begin
                if (imem_ack) begin
                    m_ir = mem[m_addr]; m_valid = 1'b1; m_mode = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_mode = 2; m_err = 1'b1;
                    end
                end
            end
            m_pc = pc_n;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("PC", PC, m_pc);
            check("IR_valid", IR_valid, m_valid);
            check("Opcode", Opcode, m_ir[7:4]);
            check("Operand", Operand, m_ir[3:0]);
            check("imem_req", imem_req, m_mode == 1);
            check("fetch_busy", fetch_busy, m_mode == 1);
            check("fetch_err", fetch_err, m_err);
            if (m_mode == 1) check("imem_addr", imem_addr, m_addr);
        end
    end

    task automatic step(input logic li, input logic inc, input logic ld, input logic sel,
                        input logic [7:0] acc, input logic ack);
        LoadIR = li; IncPC = inc; LoadPC = ld; SelPC = sel; Acc_in = acc; imem_ack = ack;
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 8'h00, 0);
    endtask

    int ack_pct;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h3A; mem[1] = 8'hC5; mem[8'h55] = 8'h47;
        CLB = 1'b0;
        LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0; Acc_in = 8'h00; imem_ack = 0;
        #3;
        check("rst_PC", PC, 8'h00);
        check("rst_IR_valid", IR_valid, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_fetch_err", fetch_err, 1'b0);
        check("rst_fetch_busy", fetch_busy, 1'b0);
        check("rst_Opcode", Opcode, 4'h0);
        @(negedge clk);
        CLB = 1'b1;
        chk_en = 1'b1;

        // Basic fetch with ack in the first request cycle
        step(1, 0, 0, 0, 8'h00, 0);
        check("t1_req", imem_req, 1'b1);
        check("t1_addr", imem_addr, 8'h00);
        step(0, 0, 0, 0, 8'h00, 1);
        check("t1_valid", IR_valid, 1'b1);
        check("t1_opcode", Opcode, 4'h3);
        check("t1_operand", Operand, 4'hA);

        // PC increments mid-fetch; address and fetched word stay at 00
        step(1, 0, 0, 0, 8'h00, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        check("t2_addr_a", imem_addr, 8'h00);
        step(0, 0, 0, 0, 8'h00, 0);
        check("t2_addr_b", imem_addr, 8'h00);
        step(0, 0, 0, 0, 8'h00, 1);
        check("t2_pc", PC, 8'h01);
        check("t2_opcode", Opcode, 4'h3);
        check("t2_operand", Operand, 4'hA);

        // PC wrap and load-beats-increment
        step(0, 0, 1, 1, 8'hFF, 0);
        check("t3_pc_ff", PC, 8'hFF);
        step(0, 1, 0, 0, 8'h00, 0);
        check("t3_pc_wrap", PC, 8'h00);
        step(0, 1, 1, 1, 8'h55, 0);
        check("t3_pc_55", PC, 8'h55);

        // Direct jump from IR operand; LoadIR during REQ is not queued
        step(1, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'h00, 1);
        check("t4_opcode", Opcode, 4'h4);
        check("t4_operand", Operand, 4'h7);
        step(0, 0, 1, 0, 8'h00, 0);
        check("t4_pc", PC, 8'h07);
        step(1, 0, 0, 0, 8'h00, 0);
        check("t4_addr", imem_addr, 8'h07);
        step(1, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'h00, 1);
        check("t4_no_second_req", imem_req, 1'b0);
        idle_steps(1);
        check("t4_still_idle", imem_req, 1'b0);

        // Timeout into sticky error, cleared only by CLB
        step(1, 0, 0, 0, 8'h00, 0);
        idle_steps(14);
        check("t5_req_held", imem_req, 1'b1);
        idle_steps(1);
        check("t5_req_drop", imem_req, 1'b0);
        check("t5_err", fetch_err, 1'b1);
        step(1, 0, 0, 0, 8'h00, 0);
        check("t5_loadir_ignored", imem_req, 1'b0);
        step(0, 0, 0, 0, 8'h00, 1);
        check("t5_valid_stays0", IR_valid, 1'b0);
        #1 CLB = 1'b0;
        #2 check("t5_err_cleared", fetch_err, 1'b0);
        CLB = 1'b1;

        // Ack on the last allowed cycle is a success
        step(1, 0, 0, 0, 8'h00, 0);
        idle_steps(14);
        step(0, 0, 0, 0, 8'h00, 1);
        check("t6_valid", IR_valid, 1'b1);
        check("t6_no_err", fetch_err, 1'b0);

        // CLB mid-request aborts; a late ack is ignored
        step(1, 0, 0, 0, 8'h00, 0);
        idle_steps(1);
        #1 CLB = 1'b0;
        #1 CLB = 1'b1;
        step(0, 0, 0, 0, 8'h00, 1);
        check("t7_ir_hi", Opcode, 4'h0);
        check("t7_ir_lo", Operand, 4'h0);
        check("t7_valid", IR_valid, 1'b0);
        check("t7_idle", imem_req, 1'b0);

        // Random traffic with varying ack density
        ack_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 4;
                    1:       ack_pct = 40;
                    default: ack_pct = 90;
                endcase
            end
            if ($urandom_range(0, 149) == 0) begin
                #1 CLB = 1'b0;
                #1 CLB = 1'b1;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0, 1'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < ack_pct);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
